trng_fetch_buffer: RTL and testbench

TRNG_FETCH_BUFFER -- requirements
Module: trng_fetch_buffer

---
 rtl/trng_pkg.sv | 16 +
 rtl/trng_word_fifo.sv | 75 +++++++
 rtl/trng_fetch_buffer.sv | 133 +++++++++++++
 tb/tb_trng_fetch_buffer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// trng_pkg: shared definitions for the TRNG fetch buffer.
//   - Default WIDTH / DEPTH / TIMEOUT values.
//   - FSM state encoding for the fetch controller.
package trng_pkg;

    localparam int unsigned DefaultWidth   = 32;
    localparam int unsigned DefaultDepth   = 4;
    localparam int unsigned DefaultTimeout = 64;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StDrop = 2'd2
    } trng_state_e;

endpackage

// File: rtl/trng_word_fifo.sv
// trng_word_fifo: first-word-fall-through FIFO for random words.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   i_push, i_push_data  write strobe and word (ignored when full)
//   i_pop             read strobe (ignored when empty)
//   o_data            head word, zero while empty
//   o_valid           FIFO non-empty
//   o_fill            occupancy, 0..DEPTH
module trng_word_fifo
    import trng_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned DEPTH = DefaultDepth
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_fill
);

    localparam int unsigned PtrW  = $clog2(DEPTH);
    localparam int unsigned FillW = PtrW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [FillW-1:0] r_fill;

    logic w_empty;
    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    assign w_empty   = (r_fill == '0);
    assign w_full    = (r_fill == FillW'(DEPTH));
    assign w_do_push = i_push & ~w_full;
    assign w_do_pop  = i_pop & ~w_empty;

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_fill <= r_fill + FillW'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_fill <= r_fill - FillW'(1);
            end
        end
    end

    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_valid = ~w_empty;
    assign o_fill  = r_fill;

endmodule

// File: rtl/trng_fetch_buffer.sv
// trng_fetch_buffer: prefetches random words from a TRNG into a small FIFO,
// applying a repetition test and a response timeout.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   trng_request (out)       request to TRNG, high only in StReq
//   trng_ready, trng_random_number (in)  TRNG handshake and word
//   out_data, out_valid (out), out_ready (in)  FWFT consumer interface
//   fill_level (out)         FIFO occupancy
//   rct_fail, timeout_err    sticky error flags, cleared by clear_err
module trng_fetch_buffer
    import trng_pkg::*;
#(
    parameter int unsigned WIDTH   = DefaultWidth,
    parameter int unsigned DEPTH   = DefaultDepth,
    parameter int unsigned TIMEOUT = DefaultTimeout
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   trng_request,
    input  logic                   trng_ready,
    input  logic [WIDTH-1:0]       trng_random_number,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] fill_level,
    output logic                   rct_fail,
    output logic                   timeout_err,
    input  logic                   clear_err
);

    localparam int unsigned FillW = $clog2(DEPTH) + 1;
    localparam int unsigned CntW  = $clog2(TIMEOUT) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    trng_state_e      r_state;
    logic             r_trng_request;
    logic [CntW-1:0]  r_wait_cnt;
    logic [WIDTH-1:0] r_hist;
    logic             r_hist_valid;
    logic             r_rct_fail;
    logic             r_timeout_err;

    logic w_dup;
    logic w_accept;
    logic w_push;
    logic w_rct_set;
    logic w_to_set;
    logic w_can_fetch;
    logic [FillW-1:0] w_fill;

    // A sampled word repeating the last accepted one is discarded.
    assign w_dup       = r_hist_valid && (trng_random_number == r_hist);
    assign w_accept    = (r_state == StReq) && trng_ready;
    assign w_push      = w_accept && !w_dup;
    assign w_rct_set   = w_accept && w_dup;
    assign w_to_set    = (r_state == StReq) && !trng_ready && (r_wait_cnt == CntLast);
    // trng_ready must be low so a word left over from before a reset is never taken.
    assign w_can_fetch = (w_fill < FillW'(DEPTH)) && !trng_ready
                         && !r_rct_fail && !r_timeout_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= StIdle;
            r_trng_request <= 1'b0;
            r_wait_cnt     <= '0;
            r_hist         <= '0;
            r_hist_valid   <= 1'b0;
            r_rct_fail     <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_can_fetch) begin
                        r_state        <= StReq;
                        r_trng_request <= 1'b1;
                        r_wait_cnt     <= '0;
                    end
                end
                StReq: begin
                    if (trng_ready) begin
                        r_state        <= StDrop;
                        r_trng_request <= 1'b0;
                        if (!w_dup) begin
                            r_hist       <= trng_random_number;
                            r_hist_valid <= 1'b1;
                        end
                    end else if (r_wait_cnt == CntLast) begin
                        r_state        <= StDrop;
                        r_trng_request <= 1'b0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CntW'(1);
                    end
                end
                StDrop: begin
                    if (!trng_ready) begin
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_state        <= StIdle;
                    r_trng_request <= 1'b0;
                end
            endcase

            // A set in the same cycle as clear_err wins.
            r_rct_fail    <= w_rct_set | (r_rct_fail & ~clear_err);
            r_timeout_err <= w_to_set | (r_timeout_err & ~clear_err);
            if (clear_err && !w_push) begin
                r_hist_valid <= 1'b0;
            end
        end
    end

    trng_word_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (trng_random_number),
        .i_pop       (out_ready),
        .o_data      (out_data),
        .o_valid     (out_valid),
        .o_fill      (w_fill)
    );

    assign fill_level   = w_fill;
    assign trng_request = r_trng_request;
    assign rct_fail     = r_rct_fail;
    assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_trng_fetch_buffer.sv
// Directed bench for trng_fetch_buffer with a small TRNG responder model.
module tb_trng_fetch_buffer;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned FW      = $clog2(DEPTH) + 1;

    localparam int ModeNone  = 0;
    localparam int ModeCount = 1;
    localparam int ModeFixed = 2;

    logic             clk;
    logic             rst;
    logic             trng_request;
    logic             trng_ready;
    logic [WIDTH-1:0] trng_random_number;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [FW-1:0]    fill_level;
    logic             rct_fail;
    logic             timeout_err;
    logic             clear_err;

    trng_fetch_buffer #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .trng_request       (trng_request),
        .trng_ready         (trng_ready),
        .trng_random_number (trng_random_number),
        .out_data           (out_data),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .fill_level         (fill_level),
        .rct_fail           (rct_fail),
        .timeout_err        (timeout_err),
        .clear_err          (clear_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bench control of the TRNG model.
    int          mode;
    logic [31:0] word_base;
    int          base_tag;
    logic        hold_ready;
    // Model-owned state.
    logic [31:0] model_val;
    int          seen_tag;
    int          produced;
    int          dly;

    initial begin
        trng_ready         = 1'b0;
        trng_random_number = '0;
        model_val          = '0;
        seen_tag           = 0;
        produced           = 0;
        dly                = 0;
    end

    // Answers a request three cycles after it is seen and holds the word
    // until the request drops.
    always @(negedge clk) begin
        if (base_tag != seen_tag) begin
            model_val = word_base;
            seen_tag  = base_tag;
        end
        if (hold_ready) begin
            dly = 0;
        end else if (!trng_request) begin
            trng_ready = 1'b0;
            dly        = 0;
        end else if (!trng_ready && mode != ModeNone) begin
            if (dly == 2) begin
                trng_ready = 1'b1;
                if (mode == ModeFixed) begin
                    trng_random_number = 32'hDEAD_BEEF;
                end else begin
                    trng_random_number = model_val;
                    model_val          = model_val + 32'd1;
                end
                produced = produced + 1;
                dly      = 0;
            end else begin
                dly = dly + 1;
            end
        end
    end

    // Request rising-edge counter and consumer scoreboard.
    int          req_count = 0;
    logic        req_prev  = 1'b0;
    logic [31:0] pop_q[$];

    always @(posedge clk) begin
        if (trng_request && !req_prev) req_count <= req_count + 1;
        req_prev <= trng_request;
        if (out_valid && out_ready) pop_q.push_back(out_data);
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_fill(input logic [FW-1:0] target, input int limit, input string tag);
        int n = 0;
        while (fill_level != target && n < limit) begin
            tick(1);
            n++;
        end
        check(tag, 64'(fill_level), 64'(target));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        int          base;
        int          n;
        int          bad;
        int          max_fill;
        logic [31:0] held_word;

        rst        = 1'b1;
        out_ready  = 1'b0;
        clear_err  = 1'b0;
        mode       = ModeCount;
        word_base  = 32'hA5A5_0001;
        base_tag   = 1;
        hold_ready = 1'b0;
        tick(3);

        // Reset values.
        check("rst_req",   64'(trng_request), 64'd0);
        check("rst_valid", 64'(out_valid),    64'd0);
        check("rst_fill",  64'(fill_level),   64'd0);
        check("rst_data",  64'(out_data),     64'd0);
        check("rst_rct",   64'(rct_fail),     64'd0);
        check("rst_to",    64'(timeout_err),  64'd0);
        rst = 1'b0;

        // Fill to full with the consumer stalled.
        wait_fill(FW'(DEPTH), 200, "fill_full");
        tick(20);
        check("full_fill",  64'(fill_level),   64'd4);
        check("full_reqs",  64'(req_count),    64'd4);
        check("full_req0",  64'(trng_request), 64'd0);
        check("full_head",  64'(out_data),     64'hA5A5_0001);

        // Pop one word; one new request refills.
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("pop1_word", 64'(pop_q[0]),    64'hA5A5_0001);
        check("pop1_head", 64'(out_data),    64'hA5A5_0002);
        check("pop1_fill", 64'(fill_level),  64'd3);
        wait_fill(FW'(DEPTH), 50, "refill");
        tick(5);
        check("refill_reqs", 64'(req_count),    64'd5);
        check("refill_req0", 64'(trng_request), 64'd0);

        // Drain, then stream with out_ready held high.
        out_ready = 1'b1;
        tick(4);
        max_fill = 0;
        for (int i = 0; i < 80; i++) begin
            tick(1);
            if (int'(fill_level) > max_fill) max_fill = int'(fill_level);
        end
        out_ready = 1'b0;
        check("stream_max_fill", 64'(max_fill <= 1), 64'd1);
        wait_fill(FW'(DEPTH), 100, "stream_refill");
        tick(20);
        check("stream_no_loss", 64'(pop_q.size() + int'(fill_level)), 64'(produced));
        check("stream_count", 64'(pop_q.size() > 12), 64'd1);
        bad = 0;
        for (int i = 0; i < pop_q.size(); i++) begin
            if (pop_q[i] != 32'hA5A5_0001 + 32'(i)) bad++;
        end
        check("stream_order", 64'(bad), 64'd0);

        // Repetition test: TRNG repeats one word.
        mode = ModeFixed;
        do_reset();
        base = req_count;
        n = 0;
        while (!rct_fail && n < 100) begin
            tick(1);
            n++;
        end
        tick(20);
        check("rct_flag", 64'(rct_fail),         64'd1);
        check("rct_fill", 64'(fill_level),       64'd1);
        check("rct_head", 64'(out_data),         64'hDEAD_BEEF);
        check("rct_reqs", 64'(req_count - base), 64'd2);
        check("rct_req0", 64'(trng_request),     64'd0);

        mode      = ModeCount;
        word_base = 32'h1234_0000;
        base_tag  = 2;
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        check("clr_rct", 64'(rct_fail), 64'd0);
        wait_fill(FW'(DEPTH), 100, "clr_resume");
        check("clr_head", 64'(out_data), 64'hDEAD_BEEF);

        // Timeout: TRNG never answers.
        mode = ModeNone;
        do_reset();
        base = req_count;
        n = 0;
        while (!trng_request && n < 20) begin
            tick(1);
            n++;
        end
        check("to_req_rise", 64'(trng_request), 64'd1);
        n = 0;
        while (!timeout_err && n < 200) begin
            tick(1);
            n++;
        end
        check("to_cycles", 64'(n),            64'(TIMEOUT));
        check("to_req0",   64'(trng_request), 64'd0);
        check("to_fill",   64'(fill_level),   64'd0);
        tick(10);
        check("to_halt",   64'(req_count - base), 64'd1);

        // Reset while a word is being presented.
        mode      = ModeCount;
        word_base = 32'h5555_0000;
        base_tag  = 3;
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        check("clr_to", 64'(timeout_err), 64'd0);
        wait_fill(FW'(2), 100, "mid_prefill");
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(trng_ready && trng_request) && n < 50);
        held_word  = trng_random_number;
        hold_ready = 1'b1;
        rst        = 1'b1;
        #1;
        check("mid_req",   64'(trng_request), 64'd0);
        check("mid_valid", 64'(out_valid),    64'd0);
        check("mid_fill",  64'(fill_level),   64'd0);
        check("mid_data",  64'(out_data),     64'd0);
        check("mid_rct",   64'(rct_fail),     64'd0);
        check("mid_to",    64'(timeout_err),  64'd0);
        tick(2);
        rst  = 1'b0;
        base = req_count;
        tick(5);
        check("mid_hold_req0", 64'(trng_request),     64'd0);
        check("mid_hold_cnt",  64'(req_count - base), 64'd0);
        hold_ready = 1'b0;
        n = 0;
        while (!trng_request && n < 30) begin
            tick(1);
            n++;
        end
        check("mid_reissue", 64'(trng_request), 64'd1);
        check("mid_fill0",   64'(fill_level),   64'd0);
        wait_fill(FW'(1), 30, "mid_fill1");
        check("mid_new_word", 64'(out_data), 64'(held_word + 32'd1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
